pack_polyvec_ctrl: RTL and testbench

- Sequencer for the 10-bit polyvec ciphertext packer in Pack_Cit.
- On i_Start, reads all KYBER_K*KYBER_N compressed coefficients from the coefficient RAM, four at a time.
- Each group of four goes through the combinational 4-coeff→5-byte packer.
- The 5 bytes leave on a valid/ready byte stream with a running byte address. For Kyber512 this is 640 bytes.

---
 rtl/pack_polyvec_ctrl_pkg.sv | 20 ++
 rtl/pack_polyvec_ctrl_shift.sv | 20 ++
 rtl/pack_polyvec_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pack_polyvec_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_polyvec_ctrl_pkg.sv
// Shared constants and FSM state type for the Kyber polyvec ciphertext packer.
package kyber_pack_pkg;

  localparam int unsigned KYBER_N    = 256;
  localparam int unsigned KYBER_K    = 2;
  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned PACK_GROUP = 4;
  localparam int unsigned PACK_BYTES = 5;
  localparam int unsigned COEFF_BITS = 10;
  localparam int unsigned POLYVEC_COMPRESSED_BYTES = KYBER_K * KYBER_N * COEFF_BITS / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CAPT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } pack_state_e;

endpackage

// File: rtl/pack_polyvec_ctrl_shift.sv
// Combinational 4-coefficient (10-bit) to 5-byte packer.
module State_Pack_Cit__Pack_PolyVec__Shift (
  input  logic [9:0] i_Coeff0,
  input  logic [9:0] i_Coeff1,
  input  logic [9:0] i_Coeff2,
  input  logic [9:0] i_Coeff3,
  output logic [7:0] o_Byte0,
  output logic [7:0] o_Byte1,
  output logic [7:0] o_Byte2,
  output logic [7:0] o_Byte3,
  output logic [7:0] o_Byte4
);

  assign o_Byte0 = i_Coeff0[7:0];
  assign o_Byte1 = {i_Coeff1[5:0], i_Coeff0[9:8]};
  assign o_Byte2 = {i_Coeff2[3:0], i_Coeff1[9:6]};
  assign o_Byte3 = {i_Coeff3[1:0], i_Coeff2[9:4]};
  assign o_Byte4 = i_Coeff3[9:2];

endmodule

// File: rtl/pack_polyvec_ctrl.sv
// Sequencer: fetches four coefficients per group, packs them and streams five
// bytes per group on a valid/ready interface with a running byte address.
module pack_polyvec_ctrl
  import kyber_pack_pkg::*;
#(
  parameter int unsigned KYBER_N            = 256,
  parameter int unsigned KYBER_K            = 2,
  parameter int unsigned i_Width            = 16,
  parameter int unsigned COEFF_BITS         = 10,
  parameter int unsigned o_Ciphertext_Width = 8,
  parameter int unsigned RD_LATENCY         = 1,
  localparam int unsigned CA_W = $clog2(KYBER_K * KYBER_N),
  localparam int unsigned CT_W = $clog2(KYBER_K * KYBER_N * COEFF_BITS / 8)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_Start,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic                          o_CoeffRdEn,
  output logic [CA_W-1:0]               o_CoeffAddr,
  input  logic [i_Width-1:0]            i_CoeffData,
  output logic [o_Ciphertext_Width-1:0] o_Ciphertext,
  output logic                          o_CtValid,
  input  logic                          i_CtReady,
  output logic [CT_W-1:0]               o_CtAddr
);

  localparam int unsigned GROUPS = KYBER_K * KYBER_N / PACK_GROUP;
  localparam int unsigned G_W    = $clog2(GROUPS);
  localparam logic [G_W-1:0] LAST_G = G_W'(GROUPS - 1);

  pack_state_e state_q, state_d;
  logic [G_W-1:0]  g_q, g_d;
  logic [1:0]      j_q, j_d;
  logic [2:0]      b_q, b_d;
  logic [CA_W-1:0] coeff_addr_q, coeff_addr_d;
  logic [CT_W-1:0] ct_addr_q, ct_addr_d;
  logic            ct_valid_q, ct_valid_d;
  logic [o_Ciphertext_Width-1:0] ct_data_q, ct_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [RD_LATENCY-1:0]      cap_vld_q, cap_vld_d;
  logic [RD_LATENCY-1:0][1:0] cap_idx_q, cap_idx_d;
  logic [3:0][COEFF_BITS-1:0] coeff_q, coeff_d;

  logic       rd_en;
  logic       hs;
  logic [2:0] sel_idx;
  logic [7:0] sel_byte;
  logic [7:0] pk_b0, pk_b1, pk_b2, pk_b3, pk_b4;
  logic       unused_hi;

  assign unused_hi = ^i_CoeffData[i_Width-1:COEFF_BITS];

  assign rd_en = (state_q == ST_FETCH);
  assign hs    = ct_valid_q && i_CtReady;

  State_Pack_Cit__Pack_PolyVec__Shift u_shift (
    .i_Coeff0 (coeff_q[0]),
    .i_Coeff1 (coeff_q[1]),
    .i_Coeff2 (coeff_q[2]),
    .i_Coeff3 (coeff_q[3]),
    .o_Byte0  (pk_b0),
    .o_Byte1  (pk_b1),
    .o_Byte2  (pk_b2),
    .o_Byte3  (pk_b3),
    .o_Byte4  (pk_b4)
  );

  // Read index j travels alongside the RAM latency so data lands in slot j.
  always_comb begin
    cap_vld_d    = cap_vld_q;
    cap_idx_d    = cap_idx_q;
    cap_vld_d[0] = rd_en;
    cap_idx_d[0] = j_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      cap_vld_d[i] = cap_vld_q[i-1];
      cap_idx_d[i] = cap_idx_q[i-1];
    end
  end

  always_comb begin
    coeff_d = coeff_q;
    if (cap_vld_q[RD_LATENCY-1]) begin
      coeff_d[cap_idx_q[RD_LATENCY-1]] = i_CoeffData[COEFF_BITS-1:0];
    end
  end

  // Byte 0 is loaded in CAPT, before coeff3 lands; B0 only depends on coeff0.
  assign sel_idx = (state_q == ST_CAPT) ? 3'd0 : b_q + 3'd1;

  always_comb begin
    sel_byte = '0;
    case (sel_idx)
      3'd0:    sel_byte = pk_b0;
      3'd1:    sel_byte = pk_b1;
      3'd2:    sel_byte = pk_b2;
      3'd3:    sel_byte = pk_b3;
      3'd4:    sel_byte = pk_b4;
      default: sel_byte = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    j_d          = j_q;
    b_d          = b_q;
    coeff_addr_d = coeff_addr_q;
    ct_addr_d    = ct_addr_q;
    ct_valid_d   = ct_valid_q;
    ct_data_d    = ct_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d      = ST_FETCH;
          g_d          = '0;
          j_d          = '0;
          coeff_addr_d = '0;
          ct_addr_d    = '0;
        end
      end
      ST_FETCH: begin
        if (j_q == 2'd3) begin
          state_d = ST_CAPT;
        end else begin
          j_d          = j_q + 2'd1;
          coeff_addr_d = coeff_addr_q + 1'b1;
        end
      end
      ST_CAPT: begin
        state_d    = ST_EMIT;
        b_d        = '0;
        ct_valid_d = 1'b1;
        ct_data_d  = o_Ciphertext_Width'(sel_byte);
      end
      ST_EMIT: begin
        if (hs) begin
          if (b_q == 3'd4) begin
            ct_valid_d = 1'b0;
            if (g_q == LAST_G) begin
              state_d = ST_DONE;
            end else begin
              state_d      = ST_FETCH;
              g_d          = g_q + 1'b1;
              j_d          = '0;
              coeff_addr_d = coeff_addr_q + 1'b1;
              ct_addr_d    = ct_addr_q + 1'b1;
            end
          end else begin
            b_d       = b_q + 3'd1;
            ct_addr_d = ct_addr_q + 1'b1;
            ct_data_d = o_Ciphertext_Width'(sel_byte);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == ST_FETCH) || (state_d == ST_CAPT) || (state_d == ST_EMIT);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      g_q          <= '0;
      j_q          <= '0;
      b_q          <= '0;
      coeff_addr_q <= '0;
      ct_addr_q    <= '0;
      ct_valid_q   <= 1'b0;
      ct_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cap_vld_q    <= '0;
      cap_idx_q    <= '0;
      coeff_q      <= '0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      j_q          <= j_d;
      b_q          <= b_d;
      coeff_addr_q <= coeff_addr_d;
      ct_addr_q    <= ct_addr_d;
      ct_valid_q   <= ct_valid_d;
      ct_data_q    <= ct_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cap_vld_q    <= cap_vld_d;
      cap_idx_q    <= cap_idx_d;
      coeff_q      <= coeff_d;
    end
  end

  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_CoeffRdEn  = rd_en;
  assign o_CoeffAddr  = coeff_addr_q;
  assign o_Ciphertext = ct_data_q;
  assign o_CtValid    = ct_valid_q;
  assign o_CtAddr     = ct_addr_q;

endmodule

// File: tb/tb_pack_polyvec_ctrl.sv
// Directed bench for pack_polyvec_ctrl with a behavioural coefficient RAM.
module tb_pack_polyvec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Start;
  logic        o_Busy;
  logic        o_Done;
  logic        o_CoeffRdEn;
  logic [8:0]  o_CoeffAddr;
  logic [15:0] i_CoeffData;
  logic [7:0]  o_Ciphertext;
  logic        o_CtValid;
  logic        i_CtReady;
  logic [9:0]  o_CtAddr;

  logic [15:0] mem [512];
  logic [15:0] rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [7:0] q_byte [$];
  logic [9:0] q_addr [$];

  always #5 clk = ~clk;

  pack_polyvec_ctrl #(
    .KYBER_N            (256),
    .KYBER_K            (2),
    .i_Width            (16),
    .COEFF_BITS         (10),
    .o_Ciphertext_Width (8),
    .RD_LATENCY         (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_Start      (i_Start),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done),
    .o_CoeffRdEn  (o_CoeffRdEn),
    .o_CoeffAddr  (o_CoeffAddr),
    .i_CoeffData  (i_CoeffData),
    .o_Ciphertext (o_Ciphertext),
    .o_CtValid    (o_CtValid),
    .i_CtReady    (i_CtReady),
    .o_CtAddr     (o_CtAddr)
  );

  always @(posedge clk) begin
    if (o_CoeffRdEn) rdata <= mem[o_CoeffAddr];
  end
  assign i_CoeffData = rdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (o_CtValid && i_CtReady) begin
        q_byte.push_back(o_Ciphertext);
        q_addr.push_back(o_CtAddr);
        last_hs_cyc <= cyc;
      end
      if (o_Done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected byte k is bits [8k+7:8k] of the little-endian 10-bit coefficient stream.
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] r;
    logic [15:0] w;
    int pos;
    r = '0;
    for (int t = 0; t < 8; t++) begin
      pos = 8 * k + t;
      w = mem[pos / 10];
      r[t] = w[pos % 10];
    end
    return r;
  endfunction

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < 512; i++) mem[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
  endtask

  task automatic start_pulse(output int st_cyc);
    @(negedge clk);
    i_Start = 1'b1;
    @(posedge clk);
    st_cyc = cyc;
    @(negedge clk);
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base_done);
    int k;
    k = 0;
    while (done_cnt == base_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done_cnt != base_done), 32'd1);
  endtask

  task automatic verify_stream(input string tag, input int hbase);
    int bad_b, bad_a;
    bad_b = 0;
    bad_a = 0;
    check({tag, "_count"}, 32'(q_byte.size() - hbase), 32'd640);
    for (int i = 0; i < 640 && hbase + i < q_byte.size(); i++) begin
      if (q_byte[hbase + i] !== exp_byte(i)) bad_b++;
      if (q_addr[hbase + i] !== 10'(i)) bad_a++;
    end
    check({tag, "_byte_errs"}, 32'(bad_b), 32'd0);
    check({tag, "_addr_errs"}, 32'(bad_a), 32'd0);
  endtask

  task automatic wait_byte(input logic [9:0] a);
    int k;
    k = 0;
    while (!(o_CtValid && o_CtAddr == a) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("wait_byte_reached", 32'(o_CtValid && o_CtAddr == a), 32'd1);
  endtask

  initial begin
    int st, hb, db;
    rst = 1'b1;
    i_Start = 1'b0;
    i_CtReady = 1'b1;
    fill_const(16'h0000);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_done", 32'(o_Done), 32'd0);
    check("rst_rden", 32'(o_CoeffRdEn), 32'd0);
    check("rst_valid", 32'(o_CtValid), 32'd0);
    check("rst_caddr", 32'(o_CoeffAddr), 32'd0);
    check("rst_ctaddr", 32'(o_CtAddr), 32'd0);
    check("rst_ct", 32'(o_Ciphertext), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-ones coefficients, ready held high: timing and wrap values.
    fill_const(16'h03FF);
    hb = q_byte.size();
    db = done_cnt;
    start_pulse(st);
    check("busy_after_start", 32'(o_Busy), 32'd1);
    check("rden_fetch", 32'(o_CoeffRdEn), 32'd1);
    wait_done("t1_done", db);
    verify_stream("t1", hb);
    check("t1_byte_ff", 32'(q_byte[hb + 100]), 32'hFF);
    check("t1_last_hs_cyc", 32'(last_hs_cyc - st), 32'd1280);
    check("t1_done_cyc", 32'(done_cyc - st), 32'd1281);
    check("t1_busy_in_done", 32'(o_Busy), 32'd0);
    check("t1_caddr_end", 32'(o_CoeffAddr), 32'd511);
    check("t1_ctaddr_end", 32'(o_CtAddr), 32'd639);
    @(negedge clk);
    check("t1_done_once", 32'(done_cnt - db), 32'd1);
    check("t1_done_low", 32'(o_Done), 32'd0);
    check("t1_valid_low", 32'(o_CtValid), 32'd0);

    // Small group 0 plus backpressure on byte 2.
    fill_const(16'h0000);
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    hb = q_byte.size();
    db = done_cnt;
    start_pulse(st);
    wait_byte(10'd2);
    i_CtReady = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_valid", 32'(o_CtValid), 32'd1);
      check("bp_data", 32'(o_Ciphertext), 32'h30);
      check("bp_addr", 32'(o_CtAddr), 32'd2);
    end
    i_CtReady = 1'b1;
    @(negedge clk);
    check("bp_next_addr", 32'(o_CtAddr), 32'd3);
    check("bp_next_valid", 32'(o_CtValid), 32'd1);
    wait_done("t2_done", db);
    check("g0_b0", 32'(q_byte[hb + 0]), 32'h01);
    check("g0_b1", 32'(q_byte[hb + 1]), 32'h08);
    check("g0_b2", 32'(q_byte[hb + 2]), 32'h30);
    check("g0_b3", 32'(q_byte[hb + 3]), 32'h00);
    check("g0_b4", 32'(q_byte[hb + 4]), 32'h01);
    verify_stream("t2", hb);

    // Upper coefficient bits are masked.
    fill_rand();
    mem[0] = 16'hFD55;
    hb = q_byte.size();
    db = done_cnt;
    start_pulse(st);
    wait_done("t3_done", db);
    check("mask_b0", 32'(q_byte[hb + 0]), 32'h55);
    check("mask_b1_lo", 32'(q_byte[hb + 1] & 8'h03), 32'h1);
    verify_stream("t3", hb);

    // Start pulsed during emit of group 5 is ignored.
    fill_rand();
    hb = q_byte.size();
    db = done_cnt;
    start_pulse(st);
    wait_byte(10'd27);
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    wait_done("t4_done", db);
    repeat (30) @(negedge clk);
    check("t4_single_done", 32'(done_cnt - db), 32'd1);
    check("t4_idle", 32'(o_Busy), 32'd0);
    verify_stream("t4", hb);

    // Reset mid-emit at byte 17, then a clean full run.
    fill_rand();
    db = done_cnt;
    start_pulse(st);
    wait_byte(10'd17);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_CtValid), 32'd0);
    check("mid_rst_busy", 32'(o_Busy), 32'd0);
    check("mid_rst_ct", 32'(o_Ciphertext), 32'd0);
    check("mid_rst_ctaddr", 32'(o_CtAddr), 32'd0);
    check("mid_rst_caddr", 32'(o_CoeffAddr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hb = q_byte.size();
    repeat (5) @(negedge clk);
    check("post_rst_no_bytes", 32'(q_byte.size() - hb), 32'd0);
    check("post_rst_valid", 32'(o_CtValid), 32'd0);
    fill_rand();
    db = done_cnt;
    start_pulse(st);
    wait_done("t5_done", db);
    check("t5_done_cyc", 32'(done_cyc - st), 32'd1281);
    verify_stream("t5", hb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
